// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [3:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [3:0] Flags;
  logic [3:0] State;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Flags, State
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Flags, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit for the ARM-subset datapath: state sequencing,
// NZCV flag storage and condition-gated write enables.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4
//   DECODE | read registers, ALU forms PC+8 for R15 reads
//   MEMADR | ALU forms load/store address
//   MEMRD  | read data memory at ALUOut
//   MEMWB  | write loaded data to Rd
//   MEMWR  | write data memory at ALUOut
//   EXECR  | ALU op on register operand
//   EXECI  | ALU op on immediate operand
//   ALUWB  | write ALUOut to Rd (not for CMP)
//   BRANCH | PC <= PC+8+offset
module multicycle_controller (
  input logic CLK,
  input logic RESET,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] flags;
  logic       cond_ex;

  // Moore controls, registered from the next state
  logic       pcw_fetch_q, irwrite_q, regw_q, memw_q, branch_q;
  logic       adrsrc_q, alusrca_q;
  logic [1:0] alusrcb_q, resultsrc_q;
  logic [3:0] aluctl_q;

  logic [3:0] cmd;
  logic       imm_op, set_l;

  assign cmd    = bus.Funct[4:1];
  assign imm_op = bus.Funct[5];
  assign set_l  = bus.Funct[0];

  always_comb begin
    cond_ex = 1'b1;
    case (bus.Cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      default: cond_ex = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b01:   state_nxt = MEMADR;
          2'b00:   state_nxt = imm_op ? EXECI : EXECR;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR: state_nxt = set_l ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      EXECR:  state_nxt = ALUWB;
      EXECI:  state_nxt = ALUWB;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= FETCH;
      flags       <= 4'b0000;
      pcw_fetch_q <= 1'b1;
      irwrite_q   <= 1'b1;
      regw_q      <= 1'b0;
      memw_q      <= 1'b0;
      branch_q    <= 1'b0;
      adrsrc_q    <= 1'b0;
      alusrca_q   <= 1'b1;
      alusrcb_q   <= 2'b10;
      resultsrc_q <= 2'b10;
      aluctl_q    <= 4'b0100;
    end else begin
      state <= state_nxt;
      // condition is judged on the flags held before this edge
      if ((state == EXECR || state == EXECI) && set_l && cond_ex)
        flags <= bus.ALUFlags;

      pcw_fetch_q <= 1'b0;
      irwrite_q   <= 1'b0;
      regw_q      <= 1'b0;
      memw_q      <= 1'b0;
      branch_q    <= 1'b0;
      adrsrc_q    <= 1'b0;
      alusrca_q   <= 1'b0;
      alusrcb_q   <= 2'b00;
      resultsrc_q <= 2'b00;
      aluctl_q    <= 4'b0000;
      case (state_nxt)
        FETCH: begin
          pcw_fetch_q <= 1'b1;
          irwrite_q   <= 1'b1;
          alusrca_q   <= 1'b1;
          alusrcb_q   <= 2'b10;
          resultsrc_q <= 2'b10;
          aluctl_q    <= 4'b0100;
        end
        DECODE: begin
          alusrca_q   <= 1'b1;
          alusrcb_q   <= 2'b10;
          resultsrc_q <= 2'b10;
          aluctl_q    <= 4'b0100;
        end
        MEMADR: begin
          alusrcb_q <= 2'b01;
          aluctl_q  <= 4'b0100;
        end
        MEMRD: adrsrc_q <= 1'b1;
        MEMWB: begin
          resultsrc_q <= 2'b01;
          regw_q      <= 1'b1;
        end
        MEMWR: begin
          adrsrc_q <= 1'b1;
          memw_q   <= 1'b1;
        end
        EXECR: aluctl_q <= cmd;
        EXECI: begin
          alusrcb_q <= 2'b01;
          aluctl_q  <= cmd;
        end
        ALUWB: regw_q <= (cmd != 4'b1010);
        BRANCH: begin
          alusrcb_q   <= 2'b01;
          resultsrc_q <= 2'b10;
          aluctl_q    <= 4'b0100;
          branch_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWrite    = pcw_fetch_q |
                          (cond_ex & (branch_q | (regw_q & (bus.Rd == 4'd15))));
  assign bus.IRWrite    = irwrite_q;
  assign bus.RegWrite   = regw_q & cond_ex;
  assign bus.MemWrite   = memw_q & cond_ex;
  assign bus.AdrSrc     = adrsrc_q;
  assign bus.ALUSrcA    = alusrca_q;
  assign bus.ALUSrcB    = alusrcb_q;
  assign bus.ResultSrc  = resultsrc_q;
  assign bus.ALUControl = aluctl_q;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.Flags      = flags;
  assign bus.State      = state;

endmodule
